// File: rtl/wfifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : wfifo_wr_arbiter
//  Purpose  : Round-robin packet arbiter sharing the single write port of an
//             async FIFO among NREQ requesters in the write clock domain.
//             A grant stays locked to one requester until its last beat is
//             accepted, so packets never interleave. A stall watchdog
//             releases a grant whose owner stops presenting data.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    wclk       in   1           write-domain clock
//    wrst       in   1           synchronous active-high reset
//    req_valid  in   NREQ        per-requester beat valid
//    req_data   in   NREQ*DSIZE  requester i data at [i*DSIZE +: DSIZE]
//    req_last   in   NREQ        beat is the last of its packet
//    req_ready  out  NREQ        beat of requester i accepted when valid&ready
//    wfull      in   1           FIFO full flag (registered, write domain)
//    winc       out  1           FIFO write enable
//    wdata      out  DSIZE       FIFO write data
//    grant_id   out  clog2(NREQ) locked requester index (valid when busy)
//    busy       out  1           grant locked
//    tout_err   out  1           one-cycle pulse on watchdog release
// ============================================================================
module wfifo_wr_arbiter #(
   parameter int NREQ  = 4,
   parameter int DSIZE = 8,
   parameter int TOUT  = 16
) (
   input  logic                     wclk,
   input  logic                     wrst,
   input  logic [NREQ-1:0]          req_valid,
   input  logic [NREQ*DSIZE-1:0]    req_data,
   input  logic [NREQ-1:0]          req_last,
   output logic [NREQ-1:0]          req_ready,
   input  logic                     wfull,
   output logic                     winc,
   output logic [DSIZE-1:0]         wdata,
   output logic [$clog2(NREQ)-1:0]  grant_id,
   output logic                     busy,
   output logic                     tout_err
);

   localparam int GW = $clog2(NREQ);
   localparam int CW = $clog2(TOUT) + 1;
   localparam logic [CW-1:0] C_CNT_LIMIT = CW'(TOUT - 1);
   localparam logic [CW-1:0] C_CNT_MAX   = {CW{1'b1}};

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_LOCK = 1'b1
   } state_t;

   state_t          state_q,    state_d;
   logic [GW-1:0]   grant_q,    grant_d;
   logic [GW-1:0]   last_q,     last_d;
   logic [CW-1:0]   cnt_q,      cnt_d;
   logic            tout_err_q, tout_err_d;

   logic [DSIZE-1:0] req_data_arr [NREQ];

   logic            above_found;
   logic [GW-1:0]   above_idx;
   logic            low_found;
   logic [GW-1:0]   low_idx;
   logic            pick_found;
   logic [GW-1:0]   pick_idx;

   logic            gnt_valid;
   logic            gnt_last;

   // Split the flat data bus into one word per requester for the output mux.
   generate
      for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
         assign req_data_arr[gi] = req_data[gi*DSIZE +: DSIZE];
      end
   endgenerate

   // Round-robin search: the lowest valid index strictly above the
   // last-served one wins; if none exists, wrap to the lowest valid index.
   // Both scans run downward so the lowest matching index is kept last.
   always_comb begin
      above_found = 1'b0;
      above_idx   = '0;
      low_found   = 1'b0;
      low_idx     = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (req_valid[i]) begin
            low_found = 1'b1;
            low_idx   = GW'(i);
            if (GW'(i) > last_q) begin
               above_found = 1'b1;
               above_idx   = GW'(i);
            end
         end
      end
      pick_found = low_found;
      pick_idx   = above_found ? above_idx : low_idx;
   end

   assign gnt_valid = req_valid[grant_q];
   assign gnt_last  = req_last[grant_q];

   // Write-port outputs are combinational so a beat moves in the same
   // cycle the FIFO reports room.
   always_comb begin
      req_ready = '0;
      if (state_q == ST_LOCK) begin
         req_ready[grant_q] = ~wfull;
      end
   end

   assign winc     = (state_q == ST_LOCK) & gnt_valid & ~wfull;
   assign wdata    = req_data_arr[grant_q];
   assign grant_id = grant_q;
   assign busy     = (state_q == ST_LOCK);
   assign tout_err = tout_err_q;

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      last_d     = last_q;
      cnt_d      = cnt_q;
      tout_err_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (pick_found) begin
               state_d = ST_LOCK;
               grant_d = pick_idx;
            end
         end
         ST_LOCK: begin
            if (gnt_valid) begin
               // Presenting data keeps the watchdog quiet even while the
               // FIFO is full; only an absent requester can time out.
               cnt_d = '0;
               if (!wfull && gnt_last) begin
                  state_d = ST_IDLE;
                  last_d  = grant_q;
               end
            end else if (cnt_q == C_CNT_LIMIT) begin
               state_d    = ST_IDLE;
               last_d     = grant_q;
               cnt_d      = '0;
               tout_err_d = 1'b1;
            end else if (cnt_q != C_CNT_MAX) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge wclk) begin
      if (wrst) begin
         state_q    <= ST_IDLE;
         grant_q    <= '0;
         last_q     <= GW'(NREQ - 1);
         cnt_q      <= '0;
         tout_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         last_q     <= last_d;
         cnt_q      <= cnt_d;
         tout_err_q <= tout_err_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_wfifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wfifo_wr_arbiter
//  Purpose  : Self-checking bench for wfifo_wr_arbiter. A behavioural model
//             (lock flag, owner, last-served index, consecutive-idle count)
//             predicts every output each cycle; directed scenarios add
//             explicit expectations on grant order and written data.
//  Revision : 1.0  initial release
// ============================================================================
module tb_wfifo_wr_arbiter;

   localparam int NREQ  = 4;
   localparam int DSIZE = 8;
   localparam int TOUT  = 16;
   localparam int GW    = $clog2(NREQ);

   logic                    wclk = 1'b0;
   logic                    wrst;
   logic [NREQ-1:0]         req_valid;
   logic [NREQ*DSIZE-1:0]   req_data;
   logic [NREQ-1:0]         req_last;
   logic [NREQ-1:0]         req_ready;
   logic                    wfull;
   logic                    winc;
   logic [DSIZE-1:0]        wdata;
   logic [GW-1:0]           grant_id;
   logic                    busy;
   logic                    tout_err;

   wfifo_wr_arbiter #(.NREQ(NREQ), .DSIZE(DSIZE), .TOUT(TOUT)) dut (
      .wclk      (wclk),
      .wrst      (wrst),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_last  (req_last),
      .req_ready (req_ready),
      .wfull     (wfull),
      .winc      (winc),
      .wdata     (wdata),
      .grant_id  (grant_id),
      .busy      (busy),
      .tout_err  (tout_err)
   );

   always #5 wclk = ~wclk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state
   bit              m_locked = 1'b0;
   int              m_g      = 0;
   int              m_last   = NREQ - 1;
   int              m_idle   = 0;
   bit              m_terr   = 1'b0;
   logic [NREQ-1:0] m_acc    = '0;

   // Observations of the DUT for directed scenarios
   int   glog[$];
   int   wlog[$];
   int   terr_seen     = 0;
   bit   obs_prev_busy = 1'b0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // One clock cycle: compare at the falling edge, advance the model at the
   // rising edge, return just after it so the caller can drive new inputs.
   task automatic cycle();
      logic [NREQ-1:0] e_ready;
      logic            e_winc;
      bit              n_locked;
      int              n_g, n_last, n_idle, c;
      bit              n_terr;
      @(negedge wclk);
      e_ready = '0;
      e_winc  = 1'b0;
      if (m_locked) begin
         e_ready[m_g] = ~wfull;
         e_winc       = req_valid[m_g] & ~wfull;
      end
      check_eq("busy",      busy,      m_locked);
      check_eq("grant_id",  grant_id,  m_g);
      check_eq("tout_err",  tout_err,  m_terr);
      check_eq("req_ready", req_ready, e_ready);
      check_eq("winc",      winc,      e_winc);
      if (e_winc) check_eq("wdata", wdata, req_data[m_g*DSIZE +: DSIZE]);
      m_acc = req_valid & e_ready;

      if (busy && !obs_prev_busy) glog.push_back(int'(grant_id));
      obs_prev_busy = busy;
      if (winc) wlog.push_back(int'(wdata));
      if (tout_err) terr_seen++;

      n_locked = m_locked;
      n_g      = m_g;
      n_last   = m_last;
      n_idle   = m_idle;
      n_terr   = 1'b0;
      if (wrst) begin
         n_locked = 1'b0;
         n_g      = 0;
         n_last   = NREQ - 1;
         n_idle   = 0;
      end else if (!m_locked) begin
         for (int k = 1; k <= NREQ; k++) begin
            c = (m_last + k) % NREQ;
            if (!n_locked && req_valid[c]) begin
               n_locked = 1'b1;
               n_g      = c;
            end
         end
      end else if (req_valid[m_g]) begin
         n_idle = 0;
         if (!wfull && req_last[m_g]) begin
            n_locked = 1'b0;
            n_last   = m_g;
         end
      end else begin
         n_idle = m_idle + 1;
         if (n_idle == TOUT) begin
            n_locked = 1'b0;
            n_last   = m_g;
            n_terr   = 1'b1;
            n_idle   = 0;
         end
      end
      @(posedge wclk);
      #1;
      m_locked = n_locked;
      m_g      = n_g;
      m_last   = n_last;
      m_idle   = n_idle;
      m_terr   = n_terr;
   endtask

   task automatic clear_inputs();
      req_valid = '0;
      req_data  = '0;
      req_last  = '0;
      wfull     = 1'b0;
   endtask

   task automatic reset_dut();
      clear_inputs();
      wrst = 1'b1;
      cycle();
      cycle();
      wrst = 1'b0;
   endtask

   task automatic rand_phase(input int ncyc, input int p_new, input int p_drop,
                             input int p_full, input int p_rst);
      for (int c = 0; c < ncyc; c++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i] && !m_acc[i]) begin
               if (int'($urandom_range(99)) < p_drop) req_valid[i] = 1'b0;
            end else begin
               req_valid[i]                = (int'($urandom_range(99)) < p_new);
               req_data[i*DSIZE +: DSIZE]  = DSIZE'($urandom);
               req_last[i]                 = ($urandom_range(2) == 0);
            end
         end
         wfull = (int'($urandom_range(99)) < p_full);
         wrst  = (int'($urandom_range(999)) < p_rst);
         cycle();
      end
      wrst = 1'b0;
   endtask

   initial begin
      int idx, t0;
      int beats[3];
      int bcnt[NREQ];

      clear_inputs();
      wrst = 1'b1;
      repeat (2) @(posedge wclk);
      #1;
      reset_dut();

      // Single 3-beat packet from requester 0.
      wlog.delete();
      beats[0] = 'h11; beats[1] = 'h22; beats[2] = 'h33;
      idx = 0;
      for (int c = 0; c < 8; c++) begin
         req_valid[0]      = (idx < 3);
         req_data[7:0]     = (idx < 3) ? DSIZE'(beats[idx]) : '0;
         req_last[0]       = (idx == 2);
         cycle();
         if (m_acc[0]) idx++;
      end
      check_eq("t1_nbeats", wlog.size(), 3);
      if (wlog.size() == 3) begin
         check_eq("t1_beat0", wlog[0], 'h11);
         check_eq("t1_beat1", wlog[1], 'h22);
         check_eq("t1_beat2", wlog[2], 'h33);
      end

      // All four requesters streaming 2-beat packets.
      reset_dut();
      glog.delete();
      for (int i = 0; i < NREQ; i++) bcnt[i] = 0;
      for (int c = 0; c < 20; c++) begin
         for (int i = 0; i < NREQ; i++) begin
            req_valid[i]               = 1'b1;
            req_data[i*DSIZE +: DSIZE] = DSIZE'(i*16 + bcnt[i]);
            req_last[i]                = (bcnt[i] % 2 == 1);
         end
         cycle();
         for (int i = 0; i < NREQ; i++) if (m_acc[i]) bcnt[i]++;
      end
      check_eq("t2_ngrant_ge5", (glog.size() >= 5), 1);
      if (glog.size() >= 5) begin
         check_eq("t2_order0", glog[0], 0);
         check_eq("t2_order1", glog[1], 1);
         check_eq("t2_order2", glog[2], 2);
         check_eq("t2_order3", glog[3], 3);
         check_eq("t2_order4", glog[4], 0);
      end

      // Requester 2 stalled by a full FIFO mid-packet.
      reset_dut();
      wlog.delete();
      req_valid = 4'b0100;
      req_data[16 +: 8] = 8'hA0;
      cycle();
      cycle();
      req_data[16 +: 8] = 8'hA1;
      wfull = 1'b1;
      t0 = terr_seen;
      repeat (20) cycle();
      check_eq("t3_stall_nbeats", wlog.size(), 1);
      check_eq("t3_stall_terr", terr_seen - t0, 0);
      wfull = 1'b0;
      cycle();
      req_data[16 +: 8] = 8'hA2;
      req_last[2] = 1'b1;
      cycle();
      req_valid = '0;
      req_last  = '0;
      cycle();
      check_eq("t3_nbeats", wlog.size(), 3);
      if (wlog.size() == 3) begin
         check_eq("t3_beat1", wlog[1], 'hA1);
         check_eq("t3_beat2", wlog[2], 'hA2);
      end

      // Requester 1 goes silent after one beat; watchdog hands over to 2.
      reset_dut();
      req_valid = 4'b0010;
      req_data[8 +: 8] = 8'h51;
      cycle();
      cycle();
      glog.delete();
      t0 = terr_seen;
      req_valid = 4'b0100;
      req_data[16 +: 8] = 8'h61;
      req_last[2] = 1'b1;
      for (int c = 0; c < 24; c++) begin
         cycle();
         if (m_acc[2]) req_valid[2] = 1'b0;
      end
      check_eq("t4_terr_once", terr_seen - t0, 1);
      check_eq("t4_regrant", (glog.size() >= 1), 1);
      if (glog.size() >= 1) check_eq("t4_next_grant", glog[0], 2);

      // Reset while requester 3 holds the lock.
      reset_dut();
      req_valid = 4'b1000;
      cycle();
      cycle();
      cycle();
      req_valid = 4'b1111;
      req_last  = 4'b1111;
      wrst = 1'b1;
      cycle();
      wrst = 1'b0;
      glog.delete();
      repeat (3) cycle();
      check_eq("t5_regrant", (glog.size() >= 1), 1);
      if (glog.size() >= 1) check_eq("t5_grant_after_rst", glog[0], 0);

      // Only requester 3 active: wrap-around re-grants it.
      reset_dut();
      glog.delete();
      req_valid = 4'b1000;
      req_last  = 4'b1000;
      repeat (6) cycle();
      check_eq("t6_ngrant_ge2", (glog.size() >= 2), 1);
      if (glog.size() >= 2) check_eq("t6_wrap_grant", glog[1], 3);

      // Randomised traffic against the model.
      reset_dut();
      rand_phase(800, 90,  2, 10, 0);
      rand_phase(800, 40,  5, 50, 5);
      rand_phase(800,  6, 30,  5, 0);
      rand_phase(300, 70,  0, 97, 0);
      rand_phase(800, 50, 10, 25, 10);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
